// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the gate BIST engine.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } bist_state_t;

   // Bit v of each table is the expected gate output for input vector v.
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;

   localparam int SETTLE_W = 8;

endpackage

// File: rtl/gate_bist_vec_gen.sv
// Vector and settle counters that pace the sweep over every gate input vector.
module gate_bist_vec_gen
   import gate_bist_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            advance,
   output logic [N_IN-1:0] vec,
   output logic            settle_done,
   output logic            last_vec
);

   logic [SETTLE_W-1:0] settle_cnt;

   // The settle counter saturates at SETTLE-1 so SAMPLE sees a stable settle_done.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         vec        <= '0;
         settle_cnt <= '0;
      end else if (advance) begin
         vec        <= vec + N_IN'(1);
         settle_cnt <= '0;
      end else if (!settle_done) begin
         settle_cnt <= settle_cnt + SETTLE_W'(1);
      end
   end

   assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));
   assign last_vec    = (vec == {N_IN{1'b1}});

endmodule

// File: rtl/gate_bist.sv
// BIST engine: sweeps all gate input vectors and checks the output against EXPECT.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int                 N_IN   = 2,
   parameter logic [2**N_IN-1:0] EXPECT = TT_AND2,
   parameter int                 SETTLE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   bist_state_t     state;
   bist_state_t     state_next;
   logic [N_IN-1:0] vec;
   logic            settle_done;
   logic            last_vec;
   logic            clear;
   logic            advance;
   logic            mismatch;
   logic [N_IN:0]   err_next;

   gate_bist_vec_gen #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) u_vec_gen (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .advance     (advance),
      .vec         (vec),
      .settle_done (settle_done),
      .last_vec    (last_vec)
   );

   assign mismatch = (dut_out != EXPECT[vec]);
   assign err_next = err_count + (N_IN+1)'(mismatch);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   if (settle_done) state_next = SAMPLE;
         SAMPLE: begin
            if (last_vec) begin
               state_next = DONE;
            end else begin
               advance    = 1'b1;
               state_next = DRIVE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters sit cleared in IDLE, so an accepted start always begins at vector 0.
   assign clear = (state == IDLE);

   // pass is resolved on the final SAMPLE edge so it is already valid while done is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         pass             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  err_count        <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
                  pass             <= 1'b0;
               end
            end
            SAMPLE: begin
               err_count <= err_next;
               if (mismatch && !first_fail_valid) begin
                  first_fail_vec   <= vec;
                  first_fail_valid <= 1'b1;
               end
               if (last_vec) begin
                  pass <= (err_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state == DRIVE) || (state == SAMPLE);
   assign done   = (state == DONE);
   assign dut_in = (state == IDLE) ? '0 : vec;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: default instance with a switchable gate, plus a SETTLE=3 instance.
module tb_gate_bist;
   import gate_bist_pkg::*;

   typedef struct {
      int err;
      int ffv;
      int ffvalid;
      int pass_e;
      int done_edge;
   } exp_t;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   int         gut_mode = 0;

   logic [1:0] dut_in0, dut_in1;
   logic       gut0, gut1;
   logic       busy0, done0, pass0, ffvalid0;
   logic       busy1, done1, pass1, ffvalid1;
   logic [2:0] err0, err1;
   logic [1:0] ffv0, ffv1;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         spurious0 = 0;
   int         spurious1 = 0;
   exp_t       sb0[$];
   exp_t       sb1[$];
   exp_t       m0, m1;

   // mode 0: AND gate, 1: OR gate, 2: output stuck at 0
   assign gut0 = (gut_mode == 0) ? (dut_in0[0] & dut_in0[1]) :
                 (gut_mode == 1) ? (dut_in0[0] | dut_in0[1]) : 1'b0;
   assign gut1 = dut_in1[0] & dut_in1[1];

   gate_bist u_dut0 (
      .clock            (clock),
      .reset            (reset),
      .start            (start0),
      .dut_in           (dut_in0),
      .dut_out          (gut0),
      .busy             (busy0),
      .done             (done0),
      .pass             (pass0),
      .err_count        (err0),
      .first_fail_vec   (ffv0),
      .first_fail_valid (ffvalid0)
   );

   gate_bist #(
      .N_IN   (2),
      .EXPECT (TT_AND2),
      .SETTLE (3)
   ) u_dut1 (
      .clock            (clock),
      .reset            (reset),
      .start            (start1),
      .dut_in           (dut_in1),
      .dut_out          (gut1),
      .busy             (busy1),
      .done             (done1),
      .pass             (pass1),
      .err_count        (err1),
      .first_fail_vec   (ffv1),
      .first_fail_valid (ffvalid1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_output(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic exp_t model(input int mode, input logic [3:0] tt, input int t0, input int settle);
      exp_t e;
      e.err     = 0;
      e.ffv     = 0;
      e.ffvalid = 0;
      for (int v = 0; v < 4; v++) begin
         logic [1:0] a;
         logic       g;
         a = v[1:0];
         g = (mode == 0) ? (a[0] & a[1]) : (mode == 1) ? (a[0] | a[1]) : 1'b0;
         if (g != tt[v]) begin
            e.err++;
            if (e.ffvalid == 0) begin
               e.ffv     = v;
               e.ffvalid = 1;
            end
         end
      end
      e.pass_e    = (e.err == 0) ? 1 : 0;
      e.done_edge = t0 + 4 * (settle + 1);
      return e;
   endfunction

   // Starts a run on the chosen instance and records the expected outcome.
   task automatic apply_stimulus(input int which, input int mode);
      if (which == 0) begin
         gut_mode = mode;
         start0   = 1'b1;
         tick();
         start0   = 1'b0;
         sb0.push_back(model(mode, TT_AND2, cyc, 1));
         check_output("busy_rise0", int'(busy0), 1);
         check_output("pass_clr0", int'(pass0), 0);
         check_output("err_clr0", int'(err0), 0);
         check_output("ffvalid_clr0", int'(ffvalid0), 0);
      end else begin
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         sb1.push_back(model(0, TT_AND2, cyc, 3));
         check_output("busy_rise1", int'(busy1), 1);
      end
   endtask

   task automatic wait_done(input int which, input int budget);
      int left;
      for (int i = 0; i < budget; i++) begin
         left = (which == 0) ? sb0.size() : sb1.size();
         if (left == 0) break;
         tick();
      end
      left = (which == 0) ? sb0.size() : sb1.size();
      check_output("done_within_budget", left, 0);
   endtask

   always @(posedge clock) begin
      #1;
      if (done0 === 1'b1) begin
         if (sb0.size() == 0) begin
            spurious0++;
         end else begin
            m0 = sb0.pop_front();
            check_output("done_edge0", cyc, m0.done_edge);
            check_output("err_count0", int'(err0), m0.err);
            check_output("first_fail_vec0", int'(ffv0), m0.ffv);
            check_output("first_fail_valid0", int'(ffvalid0), m0.ffvalid);
            check_output("pass0", int'(pass0), m0.pass_e);
            check_output("busy_at_done0", int'(busy0), 0);
         end
      end
   end

   always @(posedge clock) begin
      #1;
      if (done1 === 1'b1) begin
         if (sb1.size() == 0) begin
            spurious1++;
         end else begin
            m1 = sb1.pop_front();
            check_output("done_edge1", cyc, m1.done_edge);
            check_output("err_count1", int'(err1), m1.err);
            check_output("pass1", int'(pass1), m1.pass_e);
            check_output("first_fail_valid1", int'(ffvalid1), m1.ffvalid);
         end
      end
   end

   initial begin
      repeat (3) tick();
      check_output("rst_dut_in", int'(dut_in0), 0);
      check_output("rst_busy", int'(busy0), 0);
      check_output("rst_done", int'(done0), 0);
      check_output("rst_pass", int'(pass0), 0);
      check_output("rst_err", int'(err0), 0);
      check_output("rst_ffv", int'(ffv0), 0);
      check_output("rst_ffvalid", int'(ffvalid0), 0);

      start0 = 1'b1;
      tick();
      reset  = 1'b0;
      start0 = 1'b0;
      tick();
      check_output("start_during_reset", int'(busy0), 0);

      apply_stimulus(0, 0);
      wait_done(0, 40);
      repeat (3) tick();
      check_output("held_pass_and", int'(pass0), 1);

      apply_stimulus(0, 1);
      wait_done(0, 40);
      repeat (3) tick();
      check_output("held_ffv_or", int'(ffv0), 1);
      check_output("held_err_or", int'(err0), 2);

      apply_stimulus(0, 0);
      wait_done(0, 40);

      apply_stimulus(0, 2);
      wait_done(0, 40);
      tick();

      apply_stimulus(0, 0);
      repeat (4) tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 40);
      repeat (12) tick();
      check_output("ignored_start_no_extra_done", spurious0, 0);

      apply_stimulus(0, 1);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb0.delete();
      check_output("midrst_dut_in", int'(dut_in0), 0);
      check_output("midrst_busy", int'(busy0), 0);
      check_output("midrst_done", int'(done0), 0);
      check_output("midrst_err", int'(err0), 0);
      check_output("midrst_ffvalid", int'(ffvalid0), 0);
      repeat (12) tick();
      check_output("no_done_after_reset", spurious0, 0);

      apply_stimulus(1, 0);
      check_output("sweep_dut_in", int'(dut_in1), 0);
      for (int i = 1; i < 16; i++) begin
         tick();
         check_output("sweep_dut_in", int'(dut_in1), i / 4);
      end
      wait_done(1, 20);
      repeat (4) tick();
      check_output("no_extra_done1", spurious1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
